// File: rtl/tx_qpsk_framer.sv
// tx_qpsk_framer
//   Builds transmit frames from a byte stream: a PRE_LEN-symbol PN preamble
//   (x^6+x^5+1 m-sequence, LFSR restarted at every frame) followed by
//   PAYLOAD_BYTES bytes QPSK-mapped MSB dibit first. Each symbol is repeated
//   for SPS samples. Samples are {I[11:0],Q[11:0]}, +/-AMP two's complement.
//
// Ports
//   clk        system clock
//   rst        synchronous reset, active high
//   in_data    payload byte          (in_valid/in_ready handshake)
//   in_valid   in_data valid
//   in_ready   one-byte buffer is empty
//   out_data   {I,Q} sample          (out_valid/out_ready handshake)
//   out_valid  out_data valid
//   out_ready  sink accepts sample
//
// Configuration
//   TX_IDLE_FILL_EN  when defined, IDLE emits zero-carrier samples with
//                    out_valid=1; a frame starts only after the current zero
//                    sample has transferred.
module tx_qpsk_framer #(
    parameter int SPS           = 8,
    parameter int PRE_LEN       = 63,
    parameter int PAYLOAD_BYTES = 26,
    parameter int AMP           = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [23:0] out_data,
    output logic        out_valid,
    input  logic        out_ready
);
    localparam int SW  = (SPS > 1) ? $clog2(SPS) : 1;
    localparam int SYW = $clog2(4 * PAYLOAD_BYTES + PRE_LEN + 1);
    localparam logic [11:0] POS = 12'(AMP);
    localparam logic [11:0] NEG = 12'(-AMP);

    typedef enum logic [1:0] {IDLE, PREAMBLE, PAYLOAD} state_t;

    state_t          state, state_nxt;
    logic [7:0]      buf_data;
    logic            buf_full;
    logic [7:0]      shifter;
    logic            sh_full;
    logic [5:0]      lfsr;
    logic [SW-1:0]   samp_cnt;
    logic [SYW-1:0]  sym_cnt;

    logic xfer, accept, sym_end, pre_last, pay_last, byte_end;
    logic go, start, refill, resume, move;

    assign in_ready = !rst && !buf_full;
    assign accept   = in_valid && in_ready;
    assign xfer     = out_valid && out_ready;
    assign sym_end  = xfer && (state != IDLE) && (samp_cnt == SW'(SPS - 1));
    assign pre_last = (sym_cnt == SYW'(PRE_LEN - 1));
    assign pay_last = (sym_cnt == SYW'(4 * PAYLOAD_BYTES - 1));
    assign byte_end = sym_end && (state == PAYLOAD) && (sym_cnt[1:0] == 2'd3);

`ifdef TX_IDLE_FILL_EN
    // Leave IDLE only on a zero-sample boundary.
    assign go = buf_full && out_ready;
`else
    assign go = buf_full;
`endif
    assign start  = (state == IDLE) && go;
    // End of a byte with the next one already buffered: reload without a
    // bubble. This also covers the frame rollover into the next preamble.
    assign refill = byte_end && buf_full;
    // Underrun recovery: the shifter ran dry and a byte has now arrived.
    assign resume = (state == PAYLOAD) && !sh_full && buf_full;
    assign move   = start || refill || resume;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (start) state_nxt = PREAMBLE;
            PREAMBLE: if (sym_end && pre_last) state_nxt = PAYLOAD;
            PAYLOAD:  if (sym_end && pay_last) state_nxt = buf_full ? PREAMBLE : IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Output logic: purely from registered state, so data holds while stalled.
    always_comb begin
        out_valid = 1'b0;
        out_data  = 24'h000000;
        case (state)
`ifdef TX_IDLE_FILL_EN
            IDLE:     out_valid = !rst;
`endif
            PREAMBLE: begin
                out_valid = 1'b1;
                out_data  = lfsr[5] ? {NEG, NEG} : {POS, POS};
            end
            PAYLOAD: begin
                out_valid = sh_full;
                out_data  = {shifter[7] ? NEG : POS, shifter[6] ? NEG : POS};
            end
            default: ;
        endcase
    end

    // Datapath: byte buffer, shifter, counters, LFSR
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_data <= 8'h00;
            buf_full <= 1'b0;
            shifter  <= 8'h00;
            sh_full  <= 1'b0;
            lfsr     <= 6'b111111;
            samp_cnt <= '0;
            sym_cnt  <= '0;
        end else begin
            buf_full <= accept || (buf_full && !move);
            if (accept) buf_data <= in_data;

            if (move) begin
                shifter <= buf_data;
                sh_full <= 1'b1;
            end else if (byte_end) begin
                sh_full <= 1'b0;
            end else if (sym_end && state == PAYLOAD) begin
                shifter <= {shifter[5:0], 2'b00};
            end

            if (xfer && state != IDLE)
                samp_cnt <= sym_end ? '0 : samp_cnt + 1'b1;

            if (start)
                sym_cnt <= '0;
            else if (sym_end) begin
                if ((state == PREAMBLE && pre_last) || (state == PAYLOAD && pay_last))
                    sym_cnt <= '0;
                else
                    sym_cnt <= sym_cnt + 1'b1;
            end

            if (start || (sym_end && state == PAYLOAD && pay_last))
                lfsr <= 6'b111111;
            else if (sym_end && state == PREAMBLE)
                lfsr <= {lfsr[4:0], lfsr[5] ^ lfsr[4]};
        end
    end
endmodule

// File: tb/tb_tx_qpsk_framer.sv
// Directed bench for tx_qpsk_framer at default parameters (default build).
module tb_tx_qpsk_framer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [23:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;

    tx_qpsk_framer dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    localparam int FRAME = 1336;
    localparam int PRE_S = 504;

    typedef struct {
        int          idx;
        logic [23:0] exp;
    } vec_t;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [7:0]  feed_q[$];
    int          nfed = 0;
    int          gap_at = -1;
    int          gap_len = 0;
    bit          bp = 1'b0;

    logic [23:0] cap[0:2999];
    int          ncap = 0;
    int          first_cyc = 0;
    int          last_cyc = 0;
    int          stab_err = 0;

    logic [7:0]  fb[0:51];
    bit          chips[0:62];
    vec_t        vecs[16];

    // Byte source and sink-ready driver (decide at negedge, act after posedge).
    initial begin
        bit fire;
        forever begin
            @(negedge clk);
            fire = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (fire && feed_q.size() > 0) begin
                void'(feed_q.pop_front());
                nfed++;
            end
            if (gap_len > 0 && nfed == gap_at && in_ready) gap_len--;
            in_valid  = (feed_q.size() > 0) && !(nfed == gap_at && gap_len > 0);
            in_data   = (feed_q.size() > 0) ? feed_q[0] : 8'h00;
            out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Sample monitor: capture accepted samples, check hold during stalls.
    initial begin
        bit          prev_stall;
        logic [23:0] prev_data;
        prev_stall = 1'b0;
        prev_data  = 24'h0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                if (prev_stall && (!out_valid || out_data !== prev_data)) stab_err++;
                prev_stall = out_valid && !out_ready;
                prev_data  = out_data;
                if (out_valid && out_ready) begin
                    if (ncap < 3000) cap[ncap] = out_data;
                    if (ncap == 0) first_cyc = cyc;
                    last_cyc = cyc;
                    ncap++;
                end
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_cap(input int n, input int budget, input string name);
        int k = 0;
        while (ncap < n && k < budget) begin
            tick(1);
            k++;
        end
        if (ncap < n) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: got %0d samples expected %0d", name, ncap, n);
        end
    endtask

    function automatic logic [23:0] exp_s(input int k, input int base);
        logic [7:0] b;
        logic [1:0] d;
        int         sym;
        if (k < PRE_S) return chips[k / 8] ? 24'hC00C00 : 24'h400400;
        sym = (k - PRE_S) / 8;
        b   = fb[base + sym / 4];
        d   = 2'((b >> (6 - 2 * (sym % 4))) & 8'h03);
        return {d[1] ? 12'hC00 : 12'h400, d[0] ? 12'hC00 : 12'h400};
    endfunction

    task automatic cmp_stream(input string name, input int n, input int base0);
        int mism = 0;
        for (int k = 0; k < n; k++) begin
            logic [23:0] e;
            e = exp_s(k % FRAME, base0 + (k / FRAME) * 26);
            if (cap[k] !== e) begin
                if (mism == 0)
                    $display("FAIL %s: sample %0d got %06h expected %06h", name, k, cap[k], e);
                mism++;
            end
        end
        checks++;
        if (mism != 0) errors++;
    endtask

    task automatic push_frame(input int base, input int nbytes);
        nfed = 0;
        for (int i = 0; i < nbytes; i++) feed_q.push_back(fb[base + i]);
    endtask

    initial begin
        logic [5:0] s;
        s = 6'b111111;
        for (int i = 0; i < 63; i++) begin
            chips[i] = s[5];
            s = {s[4:0], s[5] ^ s[4]};
        end
        for (int i = 0; i < 26; i++) begin
            fb[i]      = 8'(8'h1B + i * 8'h3D);
            fb[26 + i] = fb[i] ^ 8'hFF;
        end
        // Hand-derived samples of a frame whose bytes start 1B, 58, ... and end 10.
        vecs[0]  = '{0,    24'hC00C00};
        vecs[1]  = '{47,   24'hC00C00};
        vecs[2]  = '{48,   24'h400400};
        vecs[3]  = '{87,   24'h400400};
        vecs[4]  = '{88,   24'hC00C00};
        vecs[5]  = '{95,   24'hC00C00};
        vecs[6]  = '{96,   24'h400400};
        vecs[7]  = '{504,  24'h400400};
        vecs[8]  = '{511,  24'h400400};
        vecs[9]  = '{512,  24'h400C00};
        vecs[10] = '{520,  24'hC00400};
        vecs[11] = '{528,  24'hC00C00};
        vecs[12] = '{536,  24'h400C00};
        vecs[13] = '{544,  24'h400C00};
        vecs[14] = '{552,  24'hC00400};
        vecs[15] = '{1335, 24'h400400};

        // Reset
        rst = 1'b1;
        tick(64);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        rst = 1'b0;
        #1;
        check("in_ready_after_rst", 32'(in_ready), 32'd1);
        check("idle_out_valid", 32'(out_valid), 32'd0);
        tick(2);

        // Single frame, sink always ready
        ncap = 0;
        push_frame(0, 26);
        wait_cap(FRAME, 3000, "frame_a");
        tick(5);
        check("frame_a_len", 32'(ncap), 32'(FRAME));
        check("frame_a_idle", 32'(out_valid), 32'd0);
        for (int i = 0; i < 16; i++)
            check($sformatf("vec%0d", i), 32'(cap[vecs[i].idx]), 32'(vecs[i].exp));
        cmp_stream("frame_a_stream", FRAME, 0);

        // Backpressure
        ncap = 0;
        stab_err = 0;
        bp = 1'b1;
        push_frame(0, 26);
        wait_cap(FRAME, 8000, "bp");
        bp = 1'b0;
        tick(5);
        check("bp_len", 32'(ncap), 32'(FRAME));
        check("bp_stable", 32'(stab_err), 32'd0);
        cmp_stream("bp_stream", FRAME, 0);

        // Underrun: byte index 4 withheld for 100 cycles of in_ready
        ncap = 0;
        gap_at = 4;
        gap_len = 100;
        push_frame(0, 26);
        wait_cap(PRE_S + 128, 3000, "underrun_pre");
        tick(10);
        check("underrun_valid", 32'(out_valid), 32'd0);
        check("underrun_count", 32'(ncap), 32'(PRE_S + 128));
        wait_cap(FRAME, 3000, "underrun");
        tick(5);
        gap_at = -1;
        check("underrun_len", 32'(ncap), 32'(FRAME));
        cmp_stream("underrun_stream", FRAME, 0);

        // Back-to-back frames
        ncap = 0;
        push_frame(0, 52);
        wait_cap(2 * FRAME, 6000, "b2b");
        tick(5);
        check("b2b_len", 32'(ncap), 32'(2 * FRAME));
        check("b2b_contig", 32'(last_cyc - first_cyc), 32'(2 * FRAME - 1));
        check("b2b_reload0", 32'(cap[FRAME]), 32'hC00C00);
        check("b2b_reload48", 32'(cap[FRAME + 48]), 32'h400400);
        cmp_stream("b2b_stream", 2 * FRAME, 0);

        // Reset mid-preamble discards the frame and both held bytes
        ncap = 0;
        push_frame(0, 26);
        wait_cap(100, 1000, "abort_pre");
        rst = 1'b1;
        feed_q.delete();
        tick(1);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_out_data", 32'(out_data), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd0);
        tick(3);
        rst = 1'b0;
        tick(3);
        check("abort_idle", 32'(out_valid), 32'd0);
        ncap = 0;
        push_frame(0, 26);
        wait_cap(FRAME, 3000, "after_abort");
        tick(5);
        check("after_abort_len", 32'(ncap), 32'(FRAME));
        cmp_stream("after_abort_stream", FRAME, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
